// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state and reset-cause encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rst_seq_pkg;

  // Legacy numeric state codes, kept stable for anyone decoding them in debug logic
  localparam logic [2:0] StHold      = 3'd0;
  localparam logic [2:0] StWaitLock  = 3'd1;
  localparam logic [2:0] StRelTrst   = 3'd2;
  localparam logic [2:0] StRelPeriph = 3'd3;
  localparam logic [2:0] StRelCore   = 3'd4;
  localparam logic [2:0] StRun       = 3'd5;

  typedef enum logic [2:0] {
    HOLD       = StHold,
    WAIT_LOCK  = StWaitLock,
    REL_TRST   = StRelTrst,
    REL_PERIPH = StRelPeriph,
    REL_CORE   = StRelCore,
    RUN        = StRun
  } rst_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'd0,
    CAUSE_PLL = 2'd1,
    CAUSE_BTN = 2'd2,
    CAUSE_DBG = 2'd3
  } rst_cause_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_debounce.sv
// Synchronizes and debounces the reset button, emitting a one-cycle press pulse.
// Latency: press pulse SyncStages + DebounceCycles cycles after a clean raw rise.
// Backpressure: none; the pulse is fire-and-forget.
module rst_debounce #(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic btn_press_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] DebLast = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  btn_sync;
  logic                  level_q;
  logic                  press_q;
  logic [CntW-1:0]       cnt_q;

  assign btn_sync    = sync_q[SyncStages-1];
  assign btn_press_o = press_q;

  // Bring the raw bouncing button into the clk_i domain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], btn_i};
    end
  end

  // Accept a new level only after it has disagreed with the old one for a full run
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (btn_sync != level_q) begin
        if (cnt_q == DebLast) begin
          level_q <= btn_sync;
          cnt_q   <= '0;
          press_q <= btn_sync;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Releases JTAG, peripheral and core reset domains in order; re-enters reset on abort events.
// Latency: trst_no rises 1 + SyncStages + LockStableCycles edges after POR; domains StageGapCycles apart.
// Backpressure: none; aborts are taken on the first edge after the synced event.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned SyncStages       = 2,
  parameter int unsigned DebounceCycles   = 50000,
  parameter int unsigned LockStableCycles = 1024,
  parameter int unsigned StageGapCycles   = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pll_locked_i,
  input  logic       rst_btn_i,
  input  logic       dbg_rst_req_i,
  output logic       trst_no,
  output logic       rst_periph_no,
  output logic       rst_core_no,
  output logic       seq_done_o,
  output logic [1:0] rst_cause_o
);

  localparam int unsigned CntMax = max_u(LockStableCycles, StageGapCycles);
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  // Lock wait counts LockStableCycles high samples, then releases on the next one.
  localparam logic [CntW-1:0] LockLoad = CntW'(LockStableCycles);
  // Gap states release on the StageGapCycles-th edge after entry.
  localparam logic [CntW-1:0] GapLoad  = CntW'(StageGapCycles - 1);

  logic [SyncStages-1:0] lock_sync_q;
  logic                  lock_ok;
  logic                  btn_press;
  rst_state_e            state_q, state_d;
  rst_cause_e            cause_q, cause_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  dbg_wait_q, dbg_wait_d;
  logic                  trst_q, periph_q, core_q;

  assign lock_ok = lock_sync_q[SyncStages-1];

  // Bring the asynchronous PLL lock into the clk_i domain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_sync_q <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SyncStages-2:0], pll_locked_i};
    end
  end

  rst_debounce #(
    .SyncStages     (SyncStages),
    .DebounceCycles (DebounceCycles)
  ) u_btn (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .btn_i       (rst_btn_i),
    .btn_press_o (btn_press)
  );

  // Sequencing, shared counter and abort handling (PLL beats button beats debug)
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    dbg_wait_d = dbg_wait_q;
    case (state_q)
      HOLD: begin
        state_d = WAIT_LOCK;
        cnt_d   = LockLoad;
      end
      WAIT_LOCK: begin
        if (!lock_ok) begin
          cnt_d = LockLoad;
        end else if (cnt_q == '0) begin
          state_d = REL_TRST;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      REL_TRST: begin
        // After a debug reset, the gap only starts once the request has dropped
        if (dbg_wait_q && dbg_rst_req_i) begin
          cnt_d = GapLoad;
        end else begin
          dbg_wait_d = 1'b0;
          if (cnt_q == '0) begin
            state_d = REL_PERIPH;
            cnt_d   = GapLoad;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      REL_PERIPH: begin
        if (cnt_q == '0) begin
          state_d = REL_CORE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      REL_CORE: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: begin
        if (dbg_rst_req_i) begin
          state_d    = REL_TRST;
          cnt_d      = GapLoad;
          cause_d    = CAUSE_DBG;
          dbg_wait_d = 1'b1;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase

    if (state_q != HOLD) begin
      if (!lock_ok && (state_q != WAIT_LOCK)) begin
        state_d    = HOLD;
        cnt_d      = '0;
        cause_d    = CAUSE_PLL;
        dbg_wait_d = 1'b0;
      end else if (btn_press) begin
        state_d    = HOLD;
        cnt_d      = '0;
        cause_d    = CAUSE_BTN;
        dbg_wait_d = 1'b0;
      end
    end
  end

  // State, counter and cause registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      cause_q    <= CAUSE_POR;
      dbg_wait_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      dbg_wait_q <= dbg_wait_d;
    end
  end

  // Reset lines decoded from the next state and registered, so they never glitch
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trst_q   <= 1'b0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
    end else begin
      trst_q   <= (state_d != HOLD) && (state_d != WAIT_LOCK);
      periph_q <= (state_d == REL_PERIPH) || (state_d == REL_CORE) || (state_d == RUN);
      core_q   <= (state_d == REL_CORE) || (state_d == RUN);
    end
  end

  assign trst_no       = trst_q;
  assign rst_periph_no = periph_q;
  assign rst_core_no   = core_q;
  assign seq_done_o    = core_q;
  assign rst_cause_o   = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed and randomized scenarios against an edge-count model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rst_seq_ctrl;

  localparam int S = 2;
  localparam int D = 4;
  localparam int L = 8;
  localparam int G = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       pll_locked_i = 1'b1;
  logic       rst_btn_i = 1'b0;
  logic       dbg_rst_req_i = 1'b0;
  logic       trst_no, rst_periph_no, rst_core_no, seq_done_o;
  logic [1:0] rst_cause_o;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] cur_cause = 2'd0;

  always #5 clk_i = ~clk_i;

  rst_seq_ctrl #(
    .SyncStages       (S),
    .DebounceCycles   (D),
    .LockStableCycles (L),
    .StageGapCycles   (G)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .pll_locked_i  (pll_locked_i),
    .rst_btn_i     (rst_btn_i),
    .dbg_rst_req_i (dbg_rst_req_i),
    .trst_no       (trst_no),
    .rst_periph_no (rst_periph_no),
    .rst_core_no   (rst_core_no),
    .seq_done_o    (seq_done_o),
    .rst_cause_o   (rst_cause_o)
  );

  function automatic logic [5:0] outs();
    return {trst_no, rst_periph_no, rst_core_no, seq_done_o, rst_cause_o};
  endfunction

  // Full release sequence model: trst at 'rise', periph G later, core/done 2G later
  function automatic logic [5:0] exp_vec(input int k, input int rise, input logic [1:0] cause);
    logic t, p, c;
    t = (k >= rise);
    p = (k >= rise + G);
    c = (k >= rise + 2 * G);
    return {t, p, c, c, cause};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    pll_locked_i = 1'b1;
    rst_btn_i = 1'b0;
    dbg_rst_req_i = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (outs() !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_state: got %b want %b", outs(), 6'b0);
    end
  endtask

  // Expects rst_ni low on entry; the edge after which rst_ni rises is edge 0
  task automatic test_por();
    logic [5:0] e;
    tick();
    rst_ni = 1'b1;
    for (int k = 1; k <= 1 + S + L + 2 * G + 3; k++) begin
      tick();
      e = exp_vec(k, 1 + S + L, 2'd0);
      n_cmp++;
      if (outs() !== e) begin
        n_bad++;
        $display("FAIL por edge %0d: got %b want %b", k, outs(), e);
      end
    end
    cur_cause = 2'd0;
  endtask

  // Lock drops for 'len' cycles after edge 'a' while waiting for lock
  task automatic test_lock_glitch(input int a, input int len);
    logic       raw [0:63];
    logic       samp;
    logic [5:0] e;
    int         run, rise;
    rst_ni = 1'b0;
    pll_locked_i = 1'b1;
    tick();
    tick();
    rst_ni = 1'b1;
    for (int j = 0; j < 64; j++) raw[j] = !(j >= a && j < a + len);
    // Release on the (L+1)-th consecutive high synced sample taken while waiting
    rise = 63;
    run = 0;
    for (int k = 2; k < 64; k++) begin
      samp = (k >= S + 1) ? raw[k - S - 1] : 1'b0;
      run = samp ? run + 1 : 0;
      if (run == L + 1 && rise == 63) rise = k;
    end
    for (int k = 1; k <= rise + 2 * G + 2; k++) begin
      pll_locked_i = raw[k - 1];
      tick();
      e = exp_vec(k, rise, 2'd0);
      n_cmp++;
      if (outs() !== e) begin
        n_bad++;
        $display("FAIL lock_glitch a=%0d len=%0d edge %0d: got %b want %b", a, len, k, outs(), e);
      end
    end
    pll_locked_i = 1'b1;
    cur_cause = 2'd0;
  endtask

  task automatic test_button(input int np, input bit randw);
    int         w, g, abort_k, rise;
    logic [5:0] e;
    for (int p = 0; p < np; p++) begin
      w = randw ? int'($urandom_range(1, D - 1)) : 2;
      g = randw ? int'($urandom_range(1, 3)) : 2;
      rst_btn_i = 1'b1;
      for (int i = 0; i < w + g; i++) begin
        if (i == w) rst_btn_i = 1'b0;
        tick();
        n_cmp++;
        if (outs() !== {4'b1111, cur_cause}) begin
          n_bad++;
          $display("FAIL btn_bounce pulse %0d: got %b want %b", p, outs(), {4'b1111, cur_cause});
        end
      end
    end
    rst_btn_i = 1'b1;
    abort_k = S + D + 1;
    rise = abort_k + L + 2;
    for (int k = 1; k <= rise + 2 * G + 2; k++) begin
      tick();
      e = (k < abort_k) ? {4'b1111, cur_cause} : exp_vec(k, rise, 2'd2);
      n_cmp++;
      if (outs() !== e) begin
        n_bad++;
        $display("FAIL btn_press edge %0d: got %b want %b", k, outs(), e);
      end
    end
    cur_cause = 2'd2;
    rst_btn_i = 1'b0;
    repeat (S + D + 2) tick();
  endtask

  // Debug request held for n cycles in RUN; trst stays up, the rest re-release after it drops
  task automatic test_debug(input int n);
    logic [5:0] e;
    int         d;
    d = n - 1;
    for (int k = 0; k <= d + 2 * G + 2; k++) begin
      dbg_rst_req_i = (k < n);
      tick();
      e = {1'b1, k >= d + G, k >= d + 2 * G, k >= d + 2 * G, 2'd3};
      n_cmp++;
      if (outs() !== e) begin
        n_bad++;
        $display("FAIL debug n=%0d edge %0d: got %b want %b", n, k, outs(), e);
      end
    end
    dbg_rst_req_i = 1'b0;
    cur_cause = 2'd3;
  endtask

  // Lock loss and debug request reach the FSM on the same edge: PLL wins
  task automatic test_simul();
    logic [5:0] e;
    pll_locked_i = 1'b0;
    for (int k = 1; k <= S + 1; k++) begin
      if (k == S + 1) dbg_rst_req_i = 1'b1;
      tick();
      e = (k <= S) ? {4'b1111, cur_cause} : 6'b0000_01;
      n_cmp++;
      if (outs() !== e) begin
        n_bad++;
        $display("FAIL simul edge %0d: got %b want %b", k, outs(), e);
      end
    end
    dbg_rst_req_i = 1'b0;
    pll_locked_i = 1'b1;
    // Lock back high after edge S+1, first high synced sample at 2S+2
    for (int k = S + 2; k <= 2 * S + 2 + L + 2 * G + 2; k++) begin
      tick();
      e = exp_vec(k, 2 * S + 2 + L, 2'd1);
      n_cmp++;
      if (outs() !== e) begin
        n_bad++;
        $display("FAIL simul_recover edge %0d: got %b want %b", k, outs(), e);
      end
    end
    cur_cause = 2'd1;
  endtask

  // rst_ni pulsed low while the peripheral domain is being released
  task automatic test_rst_mid();
    logic [5:0] e;
    dbg_rst_req_i = 1'b1;
    tick();
    dbg_rst_req_i = 1'b0;
    repeat (G + 1) tick();
    e = {4'b1100, 2'd3};
    n_cmp++;
    if (outs() !== e) begin
      n_bad++;
      $display("FAIL rst_mid_pre: got %b want %b", outs(), e);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== 6'b0) begin
      n_bad++;
      $display("FAIL rst_mid_async: got %b want %b", outs(), 6'b0);
    end
    test_por();
  endtask

  initial begin
    test_reset();
    test_por();
    test_lock_glitch(5, 1);
    for (int i = 0; i < 3; i++) test_lock_glitch(int'($urandom_range(1, 7)), int'($urandom_range(1, 3)));
    test_button(3, 1'b0);
    for (int i = 0; i < 2; i++) test_button(int'($urandom_range(1, 4)), 1'b1);
    test_debug(3);
    for (int i = 0; i < 3; i++) test_debug(int'($urandom_range(1, 6)));
    test_simul();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset sequencer for the FPGA top level. It sits between the board-level reset sources (PLL lock, reset push-button, debug-module non-debug reset request) and the reset inputs of the demo system. It releases the JTAG/debug, peripheral and core reset domains in a fixed order with programmable spacing. It also re-enters reset on PLL lock loss, a debounced button press or a debug request, and records the cause of the last reset.

## Interface
Parameters:
- SyncStages, 2: synchronizer flops on `pll_locked_i` and `rst_btn_i` (min 2).
- DebounceCycles, 50000: cycles a synced button level must hold before it is accepted.
- LockStableCycles, 1024: consecutive synced-lock-high cycles required before the first release.
- StageGapCycles, 64: cycles between successive domain releases.

Ports:
- clk_i  in  1  free-running reference clock (not PLL-derived).
- rst_ni  in  1  power-on reset; asynchronous assert, active-low. One clock; reset asynchronous and active-low.
- pll_locked_i  in  1  PLL lock, asynchronous to clk_i.
- rst_btn_i  in  1  reset button, active-high, asynchronous and bouncing.
- dbg_rst_req_i  in  1  debug-module ndmreset request, synchronous, level.
- trst_no  out  1  debug/JTAG domain reset, active-low.
- rst_periph_no  out  1  peripheral domain reset, active-low.
- rst_core_no  out  1  Ibex core domain reset, active-low.
- seq_done_o  out  1  high while all domains are released.
- rst_cause_o  out  2  cause of the last reset: 0 POR, 1 PLL, 2 BTN, 3 DBG.

## Operation
- Button path: SyncStages flops, then a debouncer. The debounced level changes only after the synced input differs from it for DebounceCycles consecutive cycles. `btn_press` is a one-cycle pulse on the debounced 0->1 edge.
- FSM states: HOLD, WAIT_LOCK, REL_TRST, REL_PERIPH, REL_CORE, RUN.
- HOLD: all three resets asserted. Go to WAIT_LOCK next cycle.
- WAIT_LOCK: the counter counts synced-lock-high cycles and clears to 0 on any low cycle. When the count reaches LockStableCycles, go to REL_TRST and release trst_no.
- REL_TRST: wait StageGapCycles, go to REL_PERIPH and release rst_periph_no.
- REL_PERIPH: wait StageGapCycles, go to REL_CORE and release rst_core_no. seq_done_o rises in the same cycle.
- REL_CORE is a single cycle; it then goes to RUN.
- Abort events are evaluated in every state except HOLD.
  - Synced lock low outside WAIT_LOCK, or `btn_press` anywhere: go to HOLD. All resets assert on the next edge, trst_no included.
  - `dbg_rst_req_i` in RUN: assert rst_periph_no and rst_core_no on the next edge and keep trst_no high, so the debug link survives. Then wait for the request to drop and re-enter at REL_TRST with its full gap timing.
  - `dbg_rst_req_i` outside RUN is ignored.
- Simultaneous events: priority is PLL > BTN > DBG. rst_cause_o updates on the same edge the FSM leaves its current state.
- One shared down-counter, wide enough for max(LockStableCycles, StageGapCycles). It reloads on every state entry.

## Timing
- While rst_ni is low: all resets 0, seq_done_o 0, rst_cause_o 0, FSM in HOLD, debouncer level 0, counter 0.
- All outputs are registered and glitch-free. Reset outputs only deassert synchronously to clk_i.
- Release latency after rst_ni rises, with lock already high: trst_no rises 1 (HOLD) + SyncStages + LockStableCycles edges later. rst_periph_no follows StageGapCycles edges after that, then rst_core_no StageGapCycles edges after rst_periph_no.
- Assertion latency on abort: the rst lines fall on the first edge after the synced event.
  - PLL loss: SyncStages + 1 cycles after the raw input falls.
  - Button: SyncStages + DebounceCycles + 1 cycles after the raw input rises.
  - Debug request: 1 cycle.
- rst_ni asserted mid-sequence returns to the reset values immediately (asynchronously).
- rst_cause_o holds its value until the next abort.

## Structure
- `rst_seq_pkg` holds the `rst_state_e` enum (6 states) and the `rst_cause_e` enum (POR/PLL/BTN/DBG, 2-bit).
- Sub-module `rst_debounce` (parameters SyncStages, DebounceCycles) contains the synchronizer, the debounce counter and the press pulse.
- Top module `rst_seq_ctrl` contains the lock synchronizer, the FSM, the shared counter and the output registers.

## Test plan
All scenarios use SyncStages=2, DebounceCycles=4, LockStableCycles=8, StageGapCycles=4.
- POR with lock held high: rst_ni rises at edge 0 -> trst_no=1 at edge 11, rst_periph_no=1 at edge 15, rst_core_no=1 and seq_done_o=1 at edge 19, rst_cause_o=0.
- Lock glitch in WAIT_LOCK: lock low for 1 cycle at count 5 -> counter restarts. trst_no rises 8 synced-high cycles after the glitch, not before.
- Button bounce: three 2-cycle pulses, then a steady high -> no reset from the pulses. All three resets fall 2+4+1 cycles after the steady rise; rst_cause_o=2; the sequence then restarts.
- Debug request in RUN: dbg_rst_req_i high for 3 cycles -> periph and core fall 1 cycle later while trst_no stays 1. rst_periph_no rises 4 cycles after the request drops, rst_core_no 4 cycles after that; rst_cause_o=3.
- Simultaneous lock loss and debug request in RUN -> all three resets fall, including trst_no, and rst_cause_o=1.
- rst_ni pulsed low during REL_PERIPH -> outputs go to 0 asynchronously and the full sequence repeats.
